// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//
// Sweeps the eight input combinations of a 3-input boolean function, waits
// SETTLE clock edges per combination and captures the function output into
// an 8-bit truth table (bit i = output for combination {x,y,z} = i).
//
// Optional feature: define SOP_CHECK_EN to compare the captured table with
// an expected table at the end of every sweep.
//
// Parameters:
//   SETTLE       edges between driving a combination and sampling it (1..15)
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start        request one 8-combination sweep (accepted only in IDLE)
//   s_in         output of the function under sweep
//   x, y, z      function inputs (x = MSB of the combination index)
//   busy         sweep in progress
//   done         one-cycle pulse after the last sample
//   truth_table  captured truth table (named so because "table" is a
//                reserved word)
//   expected     (SOP_CHECK_EN) reference truth table
//   match        (SOP_CHECK_EN) final table equals expected
//   err_cnt      (SOP_CHECK_EN) number of differing table bits
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s_in,
`ifdef SOP_CHECK_EN
    input  logic [7:0] expected,
    output logic       match,
    output logic [3:0] err_cnt,
`endif
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table
);

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] index_reg, index_next;
    logic [3:0] cnt_reg,   cnt_next;
    logic [7:0] table_reg, table_next;

    // A sample is taken on the edge where the settle counter has run out.
    logic sample;
    logic last_sample;
    assign sample      = (state_reg == RUN) && (cnt_reg == 4'd0);
    assign last_sample = sample && (index_reg == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            index_reg <= 3'd0;
            cnt_reg   <= 4'd0;
            table_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            cnt_reg   <= cnt_next;
            table_reg <= table_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        cnt_next   = cnt_reg;
        table_next = table_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    index_next = 3'd0;
                    cnt_next   = RELOAD;
                    table_next = 8'h00;
                end
            end
            RUN: begin
                if (cnt_reg == 4'd0) begin
                    table_next[index_reg] = s_in;
                    if (index_reg == 3'd7) begin
                        // Index returns to 0 so x/y/z read 000 in DONE.
                        state_next = DONE;
                        index_next = 3'd0;
                        cnt_next   = 4'd0;
                    end else begin
                        index_next = index_reg + 3'd1;
                        cnt_next   = RELOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                index_next = 3'd0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // The index is held at 0 outside RUN, so it drives x/y/z directly.
    assign x           = index_reg[2];
    assign y           = index_reg[1];
    assign z           = index_reg[0];
    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign truth_table = table_reg;

`ifdef SOP_CHECK_EN
    logic       match_reg;
    logic [3:0] err_reg;
    logic [7:0] diff;
    logic [3:0] diff_cnt;

    // Compare against the table as it will be after the final sample, so
    // bit 7 written on this same edge is included.
    assign diff = table_next ^ expected;

    always_comb begin
        diff_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            diff_cnt = diff_cnt + {3'b000, diff[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_reg <= 1'b0;
            err_reg   <= 4'd0;
        end else if ((state_reg == IDLE) && start) begin
            match_reg <= 1'b0;
            err_reg   <= 4'd0;
        end else if (last_sample) begin
            match_reg <= (diff == 8'h00);
            err_reg   <= diff_cnt;
        end
    end

    assign match   = match_reg;
    assign err_cnt = err_reg;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Two instances: dut1 with SETTLE=1 and dut3 with SETTLE=3. Stimulus pushes
// the expected end-of-sweep result into a per-instance queue; a monitor pops
// and compares whenever done pulses. Cycle-level details (x/y/z stepping,
// busy, ignored starts, asynchronous reset) are checked inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_truth_table_sequencer;

    typedef struct {
        logic [7:0] tbl;
        int         e0;
        int         lat;
        logic       m;
        logic [3:0] e;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       start1 = 1'b0;
    logic       tie1 = 1'b0;
    logic       s_in1;
    logic       x1, y1, z1, busy1, done1;
    logic [7:0] tt1;

    logic       start3 = 1'b0;
    logic       s_in3;
    logic       x3, y3, z3, busy3, done3;
    logic [7:0] tt3;

`ifdef SOP_CHECK_EN
    logic [7:0] expected1 = 8'hAA;
    logic [7:0] expected3 = 8'hAA;
    logic       match1, match3;
    logic [3:0] err1, err3;
`endif

    item_t q1[$];
    item_t q3[$];
    item_t it1, it3;

    // Function under sweep: SoP(1,3,5,7), i.e. s = z.
    assign s_in1 = tie1 ? 1'b1 : z1;
    assign s_in3 = z3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_in(s_in1),
`ifdef SOP_CHECK_EN
        .expected(expected1), .match(match1), .err_cnt(err1),
`endif
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
        .truth_table(tt1)
    );

    truth_table_sequencer #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .s_in(s_in3),
`ifdef SOP_CHECK_EN
        .expected(expected3), .match(match3), .err_cnt(err3),
`endif
        .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
        .truth_table(tt3)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                it1 = q1.pop_front();
                $display("sweep dut1 table=%02h latency=%0d", tt1, cyc - it1.e0);
                check("dut1_table", tt1, it1.tbl);
                check("dut1_latency", cyc - it1.e0, it1.lat);
`ifdef SOP_CHECK_EN
                check("dut1_match", match1, it1.m);
                check("dut1_err_cnt", err1, it1.e);
`endif
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_done", 1, 0);
            end else begin
                it3 = q3.pop_front();
                $display("sweep dut3 table=%02h latency=%0d", tt3, cyc - it3.e0);
                check("dut3_table", tt3, it3.tbl);
                check("dut3_latency", cyc - it3.e0, it3.lat);
`ifdef SOP_CHECK_EN
                check("dut3_match", match3, it3.m);
                check("dut3_err_cnt", err3, it3.e);
`endif
            end
        end
    end

    task automatic wait_done1(input int maxc);
        int n = 0;
        while (!done1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("dut1_done_timeout", done1, 1);
    endtask

    // Plain SETTLE=1 sweep; called at a negedge with dut1 idle.
    task automatic run1(input logic [7:0] tbl, input logic m, input logic [3:0] e);
        start1 = 1'b1;
        q1.push_back('{tbl, cyc + 1, 8, m, e});
        @(negedge clk);
        start1 = 1'b0;
`ifdef SOP_CHECK_EN
        check("match_cleared_on_start", match1, 0);
        check("err_cleared_on_start", err1, 0);
`endif
        wait_done1(40);
        @(negedge clk);
    endtask

    initial begin
        int e0a;

        // Reset state
        @(negedge clk);
        check("rst_xyz1", {x1, y1, z1}, 3'b000);
        check("rst_busy_done1", {busy1, done1}, 2'b00);
        check("rst_table1", tt1, 8'h00);
        check("rst_busy_done3", {busy3, done3, tt3}, 10'h000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // SETTLE=1: one combination per cycle, done 8 edges after E0
        start1 = 1'b1;
        q1.push_back('{8'hAA, cyc + 1, 8, 1'b1, 4'd0});
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("s1_xyz_step", {x1, y1, z1}, k);
            check("s1_busy", busy1, 1);
            @(negedge clk);
        end
        check("s1_done_cycle", {done1, busy1, x1, y1, z1}, 5'b10000);
        repeat (3) @(negedge clk);
        check("s1_table_hold", tt1, 8'hAA);

        // SETTLE=3: each combination held 3 cycles, done 24 edges after E0
        start3 = 1'b1;
        q3.push_back('{8'hAA, cyc + 1, 24, 1'b1, 4'd0});
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check("s3_xyz_hold", {x3, y3, z3}, k / 3);
            check("s3_busy", busy3, 1);
            @(negedge clk);
        end
        check("s3_done_cycle", {done3, busy3, x3, y3, z3}, 5'b10000);
        repeat (2) @(negedge clk);

        // Re-pulsed start at E0+2 and during done is ignored
        start1 = 1'b1;
        q1.push_back('{8'hAA, cyc + 1, 8, 1'b1, 4'd0});
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("repulse_index", {busy1, x1, y1, z1}, 4'b1010);
        wait_done1(20);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("start_in_done_ignored", busy1, 0);
            @(negedge clk);
        end

        // Start held high: second E0 two edges after the first done edge
        start1 = 1'b1;
        e0a = cyc + 1;
        q1.push_back('{8'hAA, e0a, 8, 1'b1, 4'd0});
        q1.push_back('{8'hAA, e0a + 10, 8, 1'b1, 4'd0});
        repeat (10) @(negedge clk);
        check("b2b_idle_gap", {busy1, done1}, 2'b00);
        @(negedge clk);
        check("b2b_second_e0", {busy1, x1, y1, z1}, 4'b1000);
        start1 = 1'b0;
        wait_done1(20);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-sweep at index 4
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_index", {x1, y1, z1}, 3'b100);
        check("pre_rst_table", tt1, 8'h0A);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {x1, y1, z1, busy1, done1}, 5'b00000);
        check("rst_async_table", tt1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_done", done1, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        run1(8'hAA, 1'b1, 4'd0);

        // Expected-table comparison
`ifdef SOP_CHECK_EN
        expected1 = 8'h55;
`endif
        run1(8'hAA, 1'b0, 4'd8);
`ifdef SOP_CHECK_EN
        expected1 = 8'hAA;
`endif
        tie1 = 1'b1;
        run1(8'hFF, 1'b0, 4'd4);
        tie1 = 1'b0;

        repeat (2) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
